decifra_bloco: RTL and testbench

DECIFRA_BLOCO -- requirements
Module: decifra_bloco

---
 rtl/decifra_bloco_if.sv | 11 +
 rtl/decifra_bloco.sv | 185 ++++++++++++++++++
 tb/tb_decifra_bloco.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/decifra_bloco_if.sv
// decifra_bloco_if: request/result bundle of the AES-128 decryption core.
interface decifra_bloco_if;
    logic         start;
    logic [127:0] bloco;
    logic [127:0] chave;
    logic [127:0] saida;
    logic         done;
    logic         busy;
    modport master (output start, bloco, chave, input saida, done, busy);
    modport slave (input start, bloco, chave, output saida, done, busy);
endinterface

// File: rtl/decifra_bloco.sv
// decifra_bloco: iterative AES-128 inverse cipher, one round per clock, round keys
// regenerated backwards from rk10 so only one key register is kept.
module decifra_bloco #(
    parameter bit INVERTE = 1'b0
) (
    input logic           clk,
    input logic           rst,
    decifra_bloco_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT} estado_t;
    estado_t      estado_q, estado_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] st_q, st_d, key_q, key_d, saida_q, saida_d;
    logic         done_q, done_d;
    logic [127:0] bloco_in, chave_in, key_fwd, key_inv, rodada;
    logic [7:0]   rc;

    function automatic logic [127:0] brev(input logic [127:0] x);
        logic [127:0] y;
        for (int k = 0; k < 16; k++) y[8*k +: 8] = x[120-8*k +: 8];
        return y;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, p;
        r = 8'h00;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = xt(p);
        end
        return r;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r, p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        logic [15:0] d;
        d = {a, a} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] isbox(input logic [7:0] a);
        return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] subrot(input logic [31:0] w);
        return {sbox(w[7:0]), sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] kexp(input logic [127:0] k, input logic [7:0] r);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[31:0] ^ subrot(k[127:96]) ^ {24'h0, r};
        w1 = k[63:32] ^ w0;
        w2 = k[95:64] ^ w1;
        w3 = k[127:96] ^ w2;
        return {w3, w2, w1, w0};
    endfunction

    function automatic logic [127:0] kinv(input logic [127:0] k, input logic [7:0] r);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[127:96] ^ k[95:64];
        w2 = k[95:64] ^ k[63:32];
        w1 = k[63:32] ^ k[31:0];
        w0 = k[31:0] ^ subrot(w3) ^ {24'h0, r};
        return {w3, w2, w1, w0};
    endfunction

    function automatic logic [31:0] imix(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a3, a2, a1, a0} = w;
        return {gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09)};
    endfunction

    function automatic logic [127:0] rodada_f(input logic [127:0] s, input logic [127:0] rk,
                                              input logic mix);
        logic [127:0] t, m;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[8*(r+4*c) +: 8] = isbox(s[8*(r+4*((c-r+4)%4)) +: 8]);
        t = t ^ rk;
        for (int c = 0; c < 4; c++) m[32*c +: 32] = imix(t[32*c +: 32]);
        return mix ? m : t;
    endfunction

    assign bloco_in = INVERTE ? brev(bus.bloco) : bus.bloco;
    assign chave_in = INVERTE ? brev(bus.chave) : bus.chave;
    assign rc       = rcon(cnt_q);
    assign key_fwd  = kexp(key_q, rc);
    assign key_inv  = kinv(key_q, rc);
    assign rodada   = rodada_f(st_q, key_inv, cnt_q != 4'd1);

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        st_d     = st_q;
        key_d    = key_q;
        saida_d  = saida_q;
        done_d   = 1'b0;
        case (estado_q)
            IDLE: if (bus.start) begin
                st_d     = bloco_in;
                key_d    = chave_in;
                cnt_d    = 4'd1;
                estado_d = EXPAND;
            end
            EXPAND: begin
                key_d    = key_fwd;
                cnt_d    = cnt_q == 4'd10 ? 4'd10 : cnt_q + 4'd1;
                st_d     = cnt_q == 4'd10 ? st_q ^ key_fwd : st_q;
                estado_d = cnt_q == 4'd10 ? DECRYPT : EXPAND;
            end
            DECRYPT: begin
                key_d    = key_inv;
                st_d     = rodada;
                cnt_d    = cnt_q - 4'd1;
                saida_d  = cnt_q == 4'd1 ? rodada : saida_q;
                done_d   = cnt_q == 4'd1;
                estado_d = cnt_q == 4'd1 ? IDLE : DECRYPT;
            end
            default: estado_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= IDLE;
            cnt_q    <= 4'd0;
            st_q     <= '0;
            key_q    <= '0;
            saida_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            st_q     <= st_d;
            key_q    <= key_d;
            saida_q  <= saida_d;
            done_q   <= done_d;
        end
    end

    assign bus.saida = INVERTE ? brev(saida_q) : saida_q;
    assign bus.done  = done_q;
    assign bus.busy  = estado_q != IDLE;
endmodule

// File: tb/tb_decifra_bloco.sv
// tb_decifra_bloco: FIPS-197 vectors, busy/abort/back-to-back behaviour of decifra_bloco.
module tb_decifra_bloco;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [127:0] exp_q[$];

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K0 = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] C0 = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
    localparam logic [127:0] P0 = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] C3 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    decifra_bloco_if b1 ();
    decifra_bloco_if b0 ();

    decifra_bloco #(.INVERTE(1'b1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    decifra_bloco #(.INVERTE(1'b0)) u0 (.clk(clk), .rst(rst), .bus(b0));

    always #5 clk = ~clk;

    task automatic pulse(input bit sel, input logic [127:0] c, input logic [127:0] k);
        @(negedge clk);
        if (sel) begin
            b1.start = 1'b1; b1.bloco = c; b1.chave = k;
        end else begin
            b0.start = 1'b1; b0.bloco = c; b0.chave = k;
        end
        @(negedge clk);
        b1.start = 1'b0;
        b0.start = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int max, output int n);
        n = 0;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk); #1;
            if (sel ? b1.done : b0.done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (b1.saida !== '0) begin failures++; $display("FAIL reset_saida got=%h want=0", b1.saida); end
        checks++; if (b1.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", b1.done); end
        checks++; if (b1.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", b1.busy); end
        checks++; if (b0.saida !== '0) begin failures++; $display("FAIL reset_saida0 got=%h want=0", b0.saida); end
        rst = 1'b0;
    endtask

    task automatic test_fips();
        int n;
        logic [127:0] e;
        exp_q.push_back(P1);
        pulse(1'b1, C1, K1);
        checks++; if (b1.busy !== 1'b1) begin failures++; $display("FAIL fips_busy got=%b want=1", b1.busy); end
        wait_done(1'b1, 30, n);
        e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        checks++; if (n !== 20) begin failures++; $display("FAIL fips_latency got=%0d want=20", n); end
        checks++; if (b1.saida !== e) begin failures++; $display("FAIL fips_saida got=%h want=%h", b1.saida, e); end
        checks++; if (b1.busy !== 1'b0) begin failures++; $display("FAIL fips_idle got=%b want=0", b1.busy); end
        @(posedge clk); #1;
        checks++; if (b1.done !== 1'b0) begin failures++; $display("FAIL fips_done_width got=%b want=0", b1.done); end
        repeat (3) @(posedge clk); #1;
        checks++; if (b1.saida !== e) begin failures++; $display("FAIL fips_hold got=%h want=%h", b1.saida, e); end
    endtask

    task automatic test_appb();
        int n;
        logic [127:0] e;
        exp_q.push_back(P2);
        pulse(1'b1, C2, K2);
        wait_done(1'b1, 30, n);
        e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        checks++; if (n !== 20) begin failures++; $display("FAIL appb_latency got=%0d want=20", n); end
        checks++; if (b1.saida !== e) begin failures++; $display("FAIL appb_saida got=%h want=%h", b1.saida, e); end
    endtask

    task automatic test_reset_mid();
        int n;
        int pulses;
        logic [127:0] e;
        pulse(1'b1, C1, K1);
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (b1.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", b1.busy); end
        checks++; if (b1.done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b want=0", b1.done); end
        checks++; if (b1.saida !== '0) begin failures++; $display("FAIL abort_saida got=%h want=0", b1.saida); end
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (b1.done) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL abort_no_done got=%0d want=0", pulses); end
        exp_q.push_back(P2);
        pulse(1'b1, C2, K2);
        wait_done(1'b1, 30, n);
        e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        checks++; if (n !== 20) begin failures++; $display("FAIL abort_restart_latency got=%0d want=20", n); end
        checks++; if (b1.saida !== e) begin failures++; $display("FAIL abort_restart_saida got=%h want=%h", b1.saida, e); end
    endtask

    task automatic test_inverte0();
        int n;
        logic [127:0] e;
        exp_q.push_back(P0);
        pulse(1'b0, C0, K0);
        wait_done(1'b0, 30, n);
        e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        checks++; if (n !== 20) begin failures++; $display("FAIL inv0_latency got=%0d want=20", n); end
        checks++; if (b0.saida !== e) begin failures++; $display("FAIL inv0_saida got=%h want=%h", b0.saida, e); end
    endtask

    task automatic test_ignore_busy();
        int first;
        int pulses;
        logic [127:0] e;
        exp_q.push_back('0);
        pulse(1'b1, C3, '0);
        first = 0;
        pulses = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (b1.done) begin
                pulses++;
                if (first == 0) first = i;
            end
            if (i >= 3 && i <= 5) begin
                b1.start = 1'b1;
                b1.bloco = {4{$urandom}};
                b1.chave = {4{$urandom}};
            end else begin
                b1.start = 1'b0;
            end
        end
        e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        checks++; if (pulses !== 1) begin failures++; $display("FAIL busy_pulses got=%0d want=1", pulses); end
        checks++; if (first !== 20) begin failures++; $display("FAIL busy_latency got=%0d want=20", first); end
        checks++; if (b1.saida !== e) begin failures++; $display("FAIL busy_saida got=%h want=%h", b1.saida, e); end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [127:0] e;
        exp_q.push_back(P1);
        pulse(1'b1, C1, K1);
        wait_done(1'b1, 30, n);
        checks++; if (n !== 20) begin failures++; $display("FAIL b2b_first_latency got=%0d want=20", n); end
        exp_q.push_back(P2);
        b1.start = 1'b1;
        b1.bloco = C2;
        b1.chave = K2;
        e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        checks++; if (b1.saida !== e) begin failures++; $display("FAIL b2b_first_saida got=%h want=%h", b1.saida, e); end
        @(posedge clk); #1;
        b1.start = 1'b0;
        checks++; if (b1.busy !== 1'b1) begin failures++; $display("FAIL b2b_restart_busy got=%b want=1", b1.busy); end
        wait_done(1'b1, 30, n);
        e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        checks++; if (n !== 20) begin failures++; $display("FAIL b2b_second_latency got=%0d want=20", n); end
        checks++; if (b1.saida !== e) begin failures++; $display("FAIL b2b_second_saida got=%h want=%h", b1.saida, e); end
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        b1.start = 1'b0; b1.bloco = '0; b1.chave = '0;
        b0.start = 1'b0; b0.bloco = '0; b0.chave = '0;
        test_reset();
        test_fips();
        test_appb();
        test_reset_mid();
        test_inverte0();
        test_ignore_busy();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
